// File: rtl/subleq_program_loader_pkg.sv
// Shared types and defaults for the SUBLEQ program loader.
// The optional checksum feature is selected by SUBLEQ_LOADER_CHECKSUM_EN.
package subleq_program_loader_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultAddrW = 8;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } ld_state_e;

endpackage

// File: rtl/subleq_ckacc.sv
// Checksum accumulator: modular running sum of payload words with clear and compare.
module subleq_ckacc #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              match
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_q <= '0;
    end else if (add_en) begin
      sum_q <= sum_q + add_data;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/subleq_program_loader.sv
// Streams a SUBLEQ image into program RAM, then releases the core from reset.
// Define SUBLEQ_LOADER_CHECKSUM_EN to treat the in_last word as a checksum.
module subleq_program_loader
  import subleq_program_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(START_ADDR + MEM_DEPTH - 1);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;

  logic accept;
  logic write_word;
  logic load_ok;

  assign in_ready = (state_q == StLoad) && !reset;
  assign accept   = in_valid && in_ready;

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  logic ck_match;

  // The final word carries the expected sum; it is compared, never stored.
  subleq_ckacc #(
    .DATA_W(DATA_W)
  ) u_ckacc (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept && in_last),
    .add_en   (accept && !in_last),
    .add_data (in_data),
    .cmp_data (in_data),
    .match    (ck_match)
  );

  assign write_word = !in_last;
  assign load_ok    = ck_match;
`else
  assign write_word = 1'b1;
  assign load_ok    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoad;
      addr_q      <= FirstAddr;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        StLoad: begin
          if (accept) begin
            if (write_word) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= in_data;
              addr_q      <= addr_q + 1'b1;
              count_q     <= count_q + 1'b1;
            end
            // Leave LOAD on this edge so no word is taken past the end of RAM.
            if (in_last) begin
              state_q <= load_ok ? StRun : StFault;
            end else if (addr_q == LastAddr) begin
              state_q <= StFault;
            end
          end
        end
        // Release one cycle after leaving LOAD so the last write lands first.
        StRun: begin
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
        end
        StFault: begin
          error_q <= 1'b1;
        end
        default: begin
          state_q <= StFault;
        end
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_subleq_program_loader.sv
// Directed bench for subleq_program_loader: a default-depth instance and a 4-word instance.
module tb_subleq_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, mem_we, cpu_reset, done, error;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;

  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, s_we, s_cpu, s_done, s_error;
  logic [7:0]  s_addr;
  logic [15:0] s_wdata;
  logic [8:0]  s_count;

  subleq_program_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  subleq_program_loader #(.MEM_DEPTH(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .in_last(s_last), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .cpu_reset(s_cpu), .done(s_done), .error(s_error), .word_count(s_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write log for the default instance, sampled mid-cycle.
  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int          s_writes = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (s_we === 1'b1) s_writes++;
  end

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        exp_ready;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_cpu;
    logic        exp_done;
    logic [8:0]  exp_count;
  } vec_t;

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    s_valid  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_burst(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] w[3];
    w[0] = d0; w[1] = d1; w[2] = d2;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin : main
    int base;
    int acc_n;
    int cyc;
    bit acc;

    vecs[0] = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0012, 1'b1, 1'b0, 9'd1};
    vecs[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 8'h01, 16'h0013, 1'b1, 1'b0, 9'd2};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h02, 16'h0003, 1'b1, 1'b0, 9'd3};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd3};

    // Reset state.
    do_reset();
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", word_count, 0);
    check("rst_small_cpu_reset", s_cpu, 1);

`ifndef SUBLEQ_LOADER_CHECKSUM_EN
    // Three-word back-to-back image.
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = vecs[k].valid;
      in_data  = vecs[k].data;
      in_last  = vecs[k].last;
      #1;
      check($sformatf("t1_ready[%0d]", k), in_ready, vecs[k].exp_ready);
      check($sformatf("t1_we[%0d]", k), mem_we, vecs[k].exp_we);
      if (vecs[k].exp_we) begin
        check($sformatf("t1_addr[%0d]", k), mem_addr, vecs[k].exp_addr);
        check($sformatf("t1_wdata[%0d]", k), mem_wdata, vecs[k].exp_wdata);
      end
      check($sformatf("t1_cpu_reset[%0d]", k), cpu_reset, vecs[k].exp_cpu);
      check($sformatf("t1_done[%0d]", k), done, vecs[k].exp_done);
      check($sformatf("t1_count[%0d]", k), word_count, vecs[k].exp_count);
      @(negedge clk);
    end

    // in_valid ignored after done.
    base = wr_addr.size();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 16'hdead;
      #1;
      check("t5_ready", in_ready, 0);
      check("t5_we", mem_we, 0);
      check("t5_done", done, 1);
      check("t5_cpu_reset", cpu_reset, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t5_no_writes", wr_addr.size() - base, 0);
    check("t5_error", error, 0);

    // Twenty words with random gaps.
    do_reset();
    reset = 1'b0;
    base  = wr_addr.size();
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 20 && cyc < 400) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 16'h0100 + 16'(acc_n);
      in_last  = (acc_n == 19);
      #1;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) acc_n++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t2_accepts", acc_n, 20);
    repeat (3) @(negedge clk);
    check("t2_writes", wr_addr.size() - base, 20);
    for (int j = 0; j < 20 && base + j < wr_addr.size(); j++) begin
      check($sformatf("t2_addr[%0d]", j), wr_addr[base+j], j);
      check($sformatf("t2_data[%0d]", j), wr_data[base+j], 16'h0100 + j);
    end
    check("t2_done", done, 1);
    check("t2_count", word_count, 20);

    // Reset after two words, then reload.
    do_reset();
    reset = 1'b0;
    base  = wr_addr.size();
    in_valid = 1'b1; in_data = 16'h0055; @(negedge clk);
    in_data = 16'h0056; @(negedge clk);
    reset = 1'b1; in_data = 16'h0057;
    #1;
    check("t4_ready_in_reset", in_ready, 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("t4_we_after_reset", mem_we, 0);
    check("t4_count_after_reset", word_count, 0);
    check("t4_cpu_reset", cpu_reset, 1);
    send_burst(16'h00a0, 16'h00a1, 16'h00a2);
    repeat (3) @(negedge clk);
    check("t4_writes", wr_addr.size() - base, 5);
    if (wr_addr.size() - base == 5) begin
      check("t4_pre_addr1", wr_addr[base+1], 1);
      check("t4_reload_addr0", wr_addr[base+2], 0);
      check("t4_reload_data0", wr_data[base+2], 16'h00a0);
      check("t4_reload_addr2", wr_addr[base+4], 2);
      check("t4_reload_data2", wr_data[base+4], 16'h00a2);
    end
    check("t4_done", done, 1);
`endif

    // Overflow on the 4-word instance.
    do_reset();
    reset = 1'b0;
    base  = s_writes;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 16'h0200 + 16'(k);
      s_last  = 1'b0;
      #1;
      check($sformatf("t3_ready[%0d]", k), s_ready, (k < 4) ? 1 : 0);
      if (k == 4) begin
        check("t3_we_last", s_we, 1);
        check("t3_addr_last", s_addr, 3);
        check("t3_wdata_last", s_wdata, 16'h0203);
        check("t3_error_early", s_error, 0);
      end
      @(negedge clk);
    end
    #1;
    check("t3_error", s_error, 1);
    check("t3_cpu_reset", s_cpu, 1);
    check("t3_done", s_done, 0);
    check("t3_we_after", s_we, 0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("t3_writes", s_writes - base, 4);
    check("t3_count", s_count, 4);
    check("t3_error_sticky", s_error, 1);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    // Checksum good then bad.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      reset = 1'b0;
      base  = wr_addr.size();
      send_burst(16'h0001, 16'h0002, (pass == 0) ? 16'h0003 : 16'h0004);
      repeat (3) @(negedge clk);
      check($sformatf("t6_writes[%0d]", pass), wr_addr.size() - base, 2);
      if (wr_addr.size() - base == 2) begin
        check($sformatf("t6_data1[%0d]", pass), wr_data[base+1], 16'h0002);
        check($sformatf("t6_addr1[%0d]", pass), wr_addr[base+1], 1);
      end
      check($sformatf("t6_done[%0d]", pass), done, (pass == 0) ? 1 : 0);
      check($sformatf("t6_error[%0d]", pass), error, (pass == 0) ? 0 : 1);
      check($sformatf("t6_cpu_reset[%0d]", pass), cpu_reset, (pass == 0) ? 0 : 1);
      check($sformatf("t6_count[%0d]", pass), word_count, 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
